// File: rtl/simple_ram_if.sv
// Bus between a requester and simple_ram: write data, word address, write strobe and registered read data.
// One operation per clk cycle; there is no handshake, so neither side can stall the other.
interface simple_ram_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr;
    logic [DATA_WIDTH-1:0] q;

    modport master (output data, output addr, output wr, input q);
    modport slave  (input data, input addr, input wr, output q);
endinterface

// File: rtl/simple_ram.sv
// Single-port write-first RAM with a registered read port; SIMPLE_RAM_CLEAR_ON_RESET_EN also clears memory in reset.
// Read latency 1 cycle; no backpressure, one operation accepted every cycle.
module simple_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    simple_ram_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_d;
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  wr_en;

    // An edge that arrives while reset is held must not commit a write.
    always_comb begin
        wr_en = bus.wr & rst_n;
        rd_d  = bus.wr ? bus.data : mem_q[bus.addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

`ifdef SIMPLE_RAM_CLEAR_ON_RESET_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[bus.addr] <= bus.data;
        end
    end
`else
    // No reset on the array so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[bus.addr] <= bus.data;
        end
    end
`endif

    assign bus.q = rd_q;
endmodule

// File: tb/tb_simple_ram.sv
// Randomised and directed checks of simple_ram against an array-based reference memory.
module tb_simple_ram;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
`ifdef SIMPLE_RAM_CLEAR_ON_RESET_EN
    localparam bit CLEAR = 1'b1;
`else
    localparam bit CLEAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    simple_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    simple_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    bit            known   [DEPTH];

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One bus operation: drive on the falling edge, check q just after the rising edge.
    task automatic do_op(input bit w, input int a, input logic [DW-1:0] d, input string tag);
        int idx;
        idx = a % DEPTH;
        @(negedge clk);
        bus.wr   = w;
        bus.addr = idx[AW-1:0];
        bus.data = d;
        @(posedge clk);
        #1;
        if (w) begin
            ref_mem[idx] = d;
            known[idx]   = 1'b1;
            check_eq(tag, bus.q, d);
        end else if (known[idx]) begin
            check_eq(tag, bus.q, ref_mem[idx]);
        end
    endtask

    // Reset asserted mid-cycle, held across edges that try to write addr wa.
    task automatic pulse_reset(input int cycles, input int wa);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_async", bus.q, '0);
        for (int i = 0; i < cycles; i++) begin
            bus.wr   = 1'b1;
            bus.addr = wa[AW-1:0];
            bus.data = $urandom;
            @(posedge clk);
            #1;
            check_eq("rst_hold", bus.q, '0);
        end
        if (CLEAR) begin
            for (int i = 0; i < DEPTH; i++) begin
                ref_mem[i] = '0;
                known[i]   = 1'b1;
            end
        end
        @(negedge clk);
        bus.wr = 1'b0;
        rst_n  = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            known[i] = 1'b0;
        end
        rst_n    = 1'b1;
        bus.wr   = 1'b0;
        bus.addr = '0;
        bus.data = '0;

        // Async reset, dropped writes during reset, idle after release.
        do_op(1'b1, 9, 32'h9999_9999, "pre_wr9");
        pulse_reset(3, 9);
        for (int i = 0; i < 3; i++) begin
            do_op(1'b0, 0, '0, "idle_after_rst");
        end
        do_op(1'b0, 9, '0, "rd9_after_rst");

        // Single write/read.
        do_op(1'b1, 3, 32'hDEAD_BEEF, "wr3");
        do_op(1'b0, 3, '0, "rd3");

        // Fill and back-to-back readback.
        for (int k = 0; k < DEPTH; k++) begin
            do_op(1'b1, k, 32'hA5A5_0000 + k, "fill_wr");
        end
        for (int k = 0; k < DEPTH; k++) begin
            do_op(1'b0, k, '0, "fill_rd");
        end

        // Depth boundary aliasing.
        do_op(1'b1, 0,  32'h1111_1111, "wr0");
        do_op(1'b1, 31, 32'h2222_2222, "wr31");
        do_op(1'b0, 0,  '0, "rd0_alias");
        do_op(1'b0, 31, '0, "rd31_alias");

        // Reset retains contents unless clearing is built in.
        do_op(1'b1, 7, 32'h1234_5678, "wr7");
        pulse_reset(2, 7);
        do_op(1'b0, 7, '0, "rd7_after_rst");
        check_eq("rd7_direct", bus.q, CLEAR ? 32'h0 : 32'h1234_5678);

        // Read hold with toggling data must not disturb mem[5].
        do_op(1'b1, 5, 32'h55AA_55AA, "wr5");
        for (int i = 0; i < 10; i++) begin
            do_op(1'b0, 5, (i % 2) ? 32'hFFFF_FFFF : 32'h0, "hold5");
        end

        // Randomised mix, with write-then-read of the same address folded in.
        for (int n = 0; n < 400; n++) begin
            int a;
            a = $urandom_range(0, DEPTH - 1);
            if ($urandom_range(0, 7) == 0) begin
                do_op(1'b1, a, $urandom, "rnd_wr_pair");
                do_op(1'b0, a, $urandom, "rnd_rd_pair");
            end else begin
                do_op(bit'($urandom_range(0, 1)), a, $urandom, "rnd_op");
            end
            if (n == 200) begin
                pulse_reset(1, $urandom_range(0, DEPTH - 1));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
